// File: rtl/uart_param.sv
// Parameterised UART: one transmitter and one receiver sharing a clock.
// Optional parity, 1-2 stop bits, internal loopback of the TX line.
module uart_param #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_busy,
   output logic                  serial_out,
   input  logic                  serial_in,
   input  logic                  loopback,
   output logic [DATA_WIDTH-1:0] received_data,
   output logic                  data_is_valid,
   output logic                  rx_error,
   output logic                  parity_error
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] DLAST = IW'(DATA_WIDTH - 1);
   localparam logic SLAST = 1'(STOP_BITS - 1);
   localparam logic HAS_PAR = (PARITY_MODE != 0);
   localparam logic ODD = (PARITY_MODE == 2);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]            tx_state;
   logic [CW-1:0]         tx_cnt;
   logic [IW-1:0]         tx_idx;
   logic                  tx_stop;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  tx_par;
   logic                  tx_tick;

   assign tx_tick = (tx_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state   <= S_IDLE;
         tx_cnt     <= '0;
         tx_idx     <= '0;
         tx_stop    <= 1'b0;
         tx_shift   <= '0;
         tx_par     <= 1'b0;
         serial_out <= 1'b1;
         o_busy     <= 1'b0;
      end else begin
         if (tx_state != S_IDLE)
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
         case (tx_state)
            S_IDLE: begin
               serial_out <= 1'b1;
               if (enable) begin
                  tx_shift   <= i_data;
                  tx_par     <= (^i_data) ^ ODD;
                  tx_cnt     <= '0;
                  tx_state   <= S_START;
                  serial_out <= 1'b0;
                  o_busy     <= 1'b1;
               end
            end
            S_START: if (tx_tick) begin
               tx_state   <= S_DATA;
               tx_idx     <= '0;
               serial_out <= tx_shift[0];
            end
            S_DATA: if (tx_tick) begin
               if (tx_idx == DLAST) begin
                  tx_stop <= 1'b0;
                  if (HAS_PAR) begin
                     tx_state   <= S_PARITY;
                     serial_out <= tx_par;
                  end else begin
                     tx_state   <= S_STOP;
                     serial_out <= 1'b1;
                  end
               end else begin
                  tx_idx     <= tx_idx + 1'b1;
                  tx_shift   <= tx_shift >> 1;
                  serial_out <= tx_shift[1];
               end
            end
            S_PARITY: if (tx_tick) begin
               tx_state   <= S_STOP;
               tx_stop    <= 1'b0;
               serial_out <= 1'b1;
            end
            S_STOP: if (tx_tick) begin
               if (tx_stop == SLAST) begin
                  tx_state <= S_IDLE;
                  o_busy   <= 1'b0;
               end else begin
                  tx_stop <= 1'b1;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   // serial_out is already a flop on clk, so loopback skips the synchroniser
   logic rx_s1, rx_s2, rx_line;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= serial_in;
         rx_s2 <= rx_s1;
      end
   end

   assign rx_line = loopback ? serial_out : rx_s2;

   logic [2:0]            rx_state;
   logic [CW-1:0]         rx_cnt;
   logic [IW-1:0]         rx_idx;
   logic                  rx_stop;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic                  rx_par_bit;
   logic                  rx_ferr;
   logic                  rx_wait;
   logic                  rx_tick;

   assign rx_tick = (rx_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state      <= S_IDLE;
         rx_cnt        <= '0;
         rx_idx        <= '0;
         rx_stop       <= 1'b0;
         rx_shift      <= '0;
         rx_par_bit    <= 1'b0;
         rx_ferr       <= 1'b0;
         rx_wait       <= 1'b0;
         received_data <= '0;
         data_is_valid <= 1'b0;
         rx_error      <= 1'b0;
         parity_error  <= 1'b0;
      end else begin
         data_is_valid <= 1'b0;
         rx_error      <= 1'b0;
         parity_error  <= 1'b0;
         if (rx_state != S_IDLE && rx_state != S_START)
            rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
         case (rx_state)
            S_IDLE: begin
               rx_cnt <= '0;
               if (rx_line)
                  rx_wait <= 1'b0;
               else if (!rx_wait)
                  rx_state <= S_START;
            end
            S_START: begin
               if (rx_cnt == HALF) begin
                  rx_cnt <= '0;
                  if (rx_line) begin
                     rx_state <= S_IDLE;
                  end else begin
                     rx_state <= S_DATA;
                     rx_idx   <= '0;
                     rx_ferr  <= 1'b0;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_DATA: if (rx_tick) begin
               rx_shift <= {rx_line, rx_shift[DATA_WIDTH-1:1]};
               if (rx_idx == DLAST) begin
                  rx_stop  <= 1'b0;
                  rx_state <= HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  rx_idx <= rx_idx + 1'b1;
               end
            end
            S_PARITY: if (rx_tick) begin
               rx_par_bit <= rx_line;
               rx_stop    <= 1'b0;
               rx_state   <= S_STOP;
            end
            S_STOP: if (rx_tick) begin
               if (rx_stop != SLAST) begin
                  rx_stop <= 1'b1;
                  if (!rx_line) rx_ferr <= 1'b1;
               end else begin
                  rx_state <= S_IDLE;
                  if (rx_ferr || !rx_line) begin
                     rx_error <= 1'b1;
                     rx_wait  <= 1'b1;
                  end else if (HAS_PAR &&
                     (rx_par_bit != ((^rx_shift) ^ ODD))) begin
                     parity_error <= 1'b1;
                  end else begin
                     received_data <= rx_shift;
                     data_is_valid <= 1'b1;
                  end
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: three instances (no/even/odd parity), event
// scoreboard for RX pulses plus directed line and status checks.
module tb_uart_param;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] enable_v = 3'b000;
   logic [2:0] loopback_v = 3'b111;
   logic [2:0] serial_in_v = 3'b111;
   logic [2:0] busy_v, so_v, dv_v, re_v, pe_v;
   logic [7:0] idata [3];
   logic [7:0] rdata [3];

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         id;
      logic [2:0] kind;
      logic [7:0] data;
   } exp_t;

   exp_t q[$];

   localparam logic [2:0] K_VALID = 3'b001;
   localparam logic [2:0] K_FERR  = 3'b010;
   localparam logic [2:0] K_PERR  = 3'b100;

   always #5 clk = ~clk;

   uart_param #(.PARITY_MODE(0)) u0 (
      .clk(clk), .reset(reset), .enable(enable_v[0]), .i_data(idata[0]),
      .o_busy(busy_v[0]), .serial_out(so_v[0]), .serial_in(serial_in_v[0]),
      .loopback(loopback_v[0]), .received_data(rdata[0]),
      .data_is_valid(dv_v[0]), .rx_error(re_v[0]), .parity_error(pe_v[0]));

   uart_param #(.PARITY_MODE(1)) u1 (
      .clk(clk), .reset(reset), .enable(enable_v[1]), .i_data(idata[1]),
      .o_busy(busy_v[1]), .serial_out(so_v[1]), .serial_in(serial_in_v[1]),
      .loopback(loopback_v[1]), .received_data(rdata[1]),
      .data_is_valid(dv_v[1]), .rx_error(re_v[1]), .parity_error(pe_v[1]));

   uart_param #(.PARITY_MODE(2)) u2 (
      .clk(clk), .reset(reset), .enable(enable_v[2]), .i_data(idata[2]),
      .o_busy(busy_v[2]), .serial_out(so_v[2]), .serial_in(serial_in_v[2]),
      .loopback(loopback_v[2]), .received_data(rdata[2]),
      .data_is_valid(dv_v[2]), .rx_error(re_v[2]), .parity_error(pe_v[2]));

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int id, input logic [2:0] k,
                            input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.kind = k;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic send(input int id, input logic [7:0] d);
      int n = 0;
      while (busy_v[id] && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_idle_wait", {31'd0, busy_v[id]}, 32'd0);
      idata[id] = d;
      enable_v[id] = 1'b1;
      @(posedge clk);
      #1;
      enable_v[id] = 1'b0;
   endtask

   task automatic drive(input int id, input logic [15:0] bits,
                        input int n);
      for (int i = 0; i < n; i++) begin
         serial_in_v[id] = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      serial_in_v[id] = 1'b1;
   endtask

   initial begin
      int n;
      idata[0] = 8'h00;
      idata[1] = 8'h00;
      idata[2] = 8'h00;

      fork
         forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               logic [2:0] obs;
               obs = {pe_v[i], re_v[i], dv_v[i]};
               if (obs != 3'b000) begin
                  checks++;
                  if (q.size() == 0) begin
                     failures++;
                     $display("FAIL unexpected_event dut=%0d kind=%b data=%h expected none",
                              i, obs, rdata[i]);
                  end else begin
                     exp_t e;
                     e = q.pop_front();
                     if (e.id != i || e.kind != obs || e.data !== rdata[i]) begin
                        failures++;
                        $display("FAIL rx_event: got dut=%0d kind=%b data=%h expected dut=%0d kind=%b data=%h",
                                 i, obs, rdata[i], e.id, e.kind, e.data);
                     end
                  end
               end
            end
         end
      join_none

      // enable held during reset must not start a frame
      enable_v = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_serial_out", {31'd0, so_v[i]}, 32'd1);
         chk("reset_busy", {31'd0, busy_v[i]}, 32'd0);
         chk("reset_rdata", {24'd0, rdata[i]}, 32'd0);
      end
      reset = 1'b0;
      enable_v = 3'b000;
      @(posedge clk);
      #1;
      chk("enable_in_reset_ignored", {31'd0, busy_v[0]}, 32'd0);

      // loopback 0xA5, no parity, latency window
      expect_ev(0, K_VALID, 8'hA5);
      send(0, 8'hA5);
      chk("busy_after_accept", {31'd0, busy_v[0]}, 32'd1);
      chk("start_bit_low", {31'd0, so_v[0]}, 32'd0);
      n = 0;
      while (!dv_v[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("latency_in_window", {31'd0, (n >= 144 && n <= 164)}, 32'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("busy_after_frame", {31'd0, busy_v[0]}, 32'd0);

      // parity bit on the line: 0x07 even -> 1, odd -> 0
      expect_ev(1, K_VALID, 8'h07);
      send(1, 8'h07);
      repeat (151) @(posedge clk);
      @(negedge clk);
      chk("even_parity_bit", {31'd0, so_v[1]}, 32'd1);
      repeat (60) @(posedge clk);
      #1;
      expect_ev(2, K_VALID, 8'h07);
      send(2, 8'h07);
      repeat (151) @(posedge clk);
      @(negedge clk);
      chk("odd_parity_bit", {31'd0, so_v[2]}, 32'd0);
      repeat (60) @(posedge clk);
      #1;

      // external line: 0x3C with stop bit 0 -> framing error
      loopback_v = 3'b000;
      expect_ev(0, K_FERR, 8'hA5);
      drive(0, 16'b0_00111100_0, 10);
      repeat (40) @(posedge clk);
      #1;

      // even parity: good 0x5A, then 0x01 with parity 0
      expect_ev(1, K_VALID, 8'h5A);
      drive(1, 16'b1_0_01011010_0, 11);
      repeat (40) @(posedge clk);
      #1;
      expect_ev(1, K_PERR, 8'h5A);
      drive(1, 16'b1_0_00000001_0, 11);
      repeat (40) @(posedge clk);
      #1;

      // 3-cycle glitch is rejected
      serial_in_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      serial_in_v[0] = 1'b1;
      repeat (60) @(posedge clk);
      #1;

      // enable while busy is ignored
      loopback_v = 3'b111;
      expect_ev(0, K_VALID, 8'h22);
      send(0, 8'h22);
      repeat (20) @(posedge clk);
      #1;
      idata[0] = 8'h11;
      enable_v[0] = 1'b1;
      @(posedge clk);
      #1;
      enable_v[0] = 1'b0;
      chk("busy_during_frame", {31'd0, busy_v[0]}, 32'd1);
      repeat (200) @(posedge clk);
      #1;

      // reset mid-frame aborts both directions
      send(0, 8'hFF);
      repeat (49) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_serial_out", {31'd0, so_v[0]}, 32'd1);
      chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      reset = 1'b0;
      repeat (250) @(posedge clk);
      #1;

      chk("scoreboard_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter DATA_WIDTH, 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, 16, clk cycles per bit period; legal minimum 4.
REQ-003 Parameter PARITY_MODE, 0, parity selection: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 enable  input  1  transmit request; sampled only when o_busy=0.
REQ-008 i_data  input  DATA_WIDTH  transmit data; captured on acceptance.
REQ-009 o_busy  output  1  transmitter occupied.
REQ-010 serial_out  output  1  TX line; idle high.
REQ-011 serial_in  input  1  external RX line; asynchronous.
REQ-012 loopback  input  1  1 = RX input is internal serial_out; serial_in ignored.
REQ-013 received_data  output  DATA_WIDTH  last good received word.
REQ-014 data_is_valid  output  1  one-cycle pulse per good frame.
REQ-015 rx_error  output  1  one-cycle pulse on framing error.
REQ-016 parity_error  output  1  one-cycle pulse on parity mismatch.

Function
REQ-017 Frame SHALL be: start (0), DATA_WIDTH bits LSB first, parity bit if PARITY_MODE!=0, STOP_BITS stop bits (1); frame length N = 1+DATA_WIDTH+(PARITY_MODE!=0)+STOP_BITS bits.
REQ-018 Every bit SHALL last exactly CLKS_PER_BIT cycles on serial_out; serial_out SHALL be a registered output.
REQ-019 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
REQ-020 In IDLE, enable=1 SHALL capture i_data and move to START; o_busy SHALL be 1 from the next cycle until the last stop bit completes.
REQ-021 enable while o_busy=1 SHALL be ignored; captured data SHALL not change.
REQ-022 After the last stop bit, TX SHALL return to IDLE with o_busy=0; back-to-back frames allowed with no extra idle bit.
REQ-023 Parity bit: even = XOR of data bits; odd = inverted XOR.
REQ-024 RX input SHALL pass through a 2-flop synchroniser (bypassed by the loopback path only if it is already synchronous; latency then shrinks, still within REQ-029).
REQ-025 RX FSM states: IDLE, START, DATA, PARITY, STOP; in IDLE a low on the synchronised line SHALL start a half-bit (CLKS_PER_BIT/2) wait.
REQ-026 A line found high at mid-start SHALL return RX to IDLE with no output pulse (glitch rejection).
REQ-027 Subsequent bits SHALL be sampled every CLKS_PER_BIT cycles at bit centre.
REQ-028 At frame end exactly one of: data_is_valid (all stop bits 1, parity ok, received_data updated same cycle), rx_error (any stop bit 0; takes priority), parity_error (stop ok, parity wrong); received_data unchanged on error.
REQ-029 In loopback, data_is_valid SHALL pulse no earlier than (N-1)*CLKS_PER_BIT and no later than N*CLKS_PER_BIT+4 cycles after acceptance.
REQ-030 After a framing error, RX SHALL wait for the line high before re-arming.
REQ-031 TX and RX SHALL operate concurrently and independently.

Reset
REQ-032 reset=1 SHALL force serial_out=1, o_busy=0, data_is_valid=0, rx_error=0, parity_error=0, received_data=0, both FSMs IDLE, on the next edge.
REQ-033 reset mid-frame SHALL abort both frames; no pulse for the aborted RX frame.
REQ-034 enable asserted together with reset SHALL be ignored.

Verification
REQ-035 DW=8, CPB=16, parity none, 1 stop, loopback=1, send 0xA5 -> data_is_valid once within 164 cycles, received_data=0xA5, no error pulses.
REQ-036 PARITY_MODE=1, send 0x07 -> serial_out parity-bit period = 1; loopback receive 0x07 valid; PARITY_MODE=2 -> parity bit 0.
REQ-037 loopback=0, drive serial_in frame 0x3C with stop bit 0 -> rx_error pulse, no data_is_valid, received_data unchanged.
REQ-038 loopback=0, even parity, drive 0x01 with parity bit 0 -> parity_error pulse only.
REQ-039 enable pulsed with 0x11 while busy sending 0x22 -> only 0x22 transmitted; 3-cycle low glitch on serial_in -> no pulses.
REQ-040 reset at cycle 50 of a 0xFF frame -> serial_out=1, o_busy=0 next cycle; no data_is_valid follows.
